vga_driver: RTL and testbench
=============================

# vga_driver

Timing generator for the 1280x1024 @ 60 Hz VGA output path, running on the 108 MHz pixel clock. It produces the pixel coordinates consumed by the pattern generator (`display_vga`). It accepts that stage's RGB565 data a fixed number of cycles later. It then drives the delay-aligned hsync, vsync, data-enable and split RGB pins to the DAC/connector.

## Interface
Parameters:
- `H_DISP`, 1280, active pixels per line
- `H_FRONT`, 48, horizontal front porch
- `H_SYNC`, 112, hsync width
- `H_BACK`, 248, horizontal back porch (H_TOTAL = 1688)
- `V_DISP`, 1024, active lines
- `V_FRONT`, 1, vertical front porch
- `V_SYNC`, 3, vsync width
- `V_BACK`, 38, vertical back porch (V_TOTAL = 1066)
- `H_POL`, 1'b1, hsync active level
- `V_POL`, 1'b1, vsync active level
- `LATENCY`, 2, cycles from coordinate out to matching data in; legal range 1..7

Ports:
- `clk_vga_driver`, in, 1, pixel clock. Single clock domain.
- `rst_vga_driver`, in, 1. Reset is synchronous and active-high.
- `xpos_vga_driver`, out, 12, requested pixel column; 0 outside the active region.
- `ypos_vga_driver`, out, 12, requested pixel row; 0 outside the active region.
- `frame_start_vga_driver`, out, 1, one-cycle pulse at counter origin (h=0, v=0).
- `data_vga_driver`, in, 16, RGB565 pixel for the coordinate issued LATENCY cycles earlier.
- `vga_hs`, out, 1, horizontal sync.
- `vga_vs`, out, 1, vertical sync.
- `vga_de`, out, 1, active video.
- `vga_r`, out, 5, red; `vga_g`, out, 6, green; `vga_b`, out, 5, blue.

## Operation
- 12-bit counters `h_cnt` (0..H_TOTAL-1) and `v_cnt` (0..V_TOTAL-1).
  - `h_cnt` wraps to 0 after H_TOTAL-1; `v_cnt` increments only on that wrap.
  - `v_cnt` wraps to 0 after V_TOTAL-1.
- Region order per line/frame: display, front porch, sync, back porch.
- Raw signals are combinational from the counters:
  - active = (h_cnt < H_DISP) && (v_cnt < V_DISP)
  - hs_raw = h_cnt in [H_DISP+H_FRONT, H_DISP+H_FRONT+H_SYNC), i.e. 1328..1439
  - vs_raw = v_cnt in [V_DISP+V_FRONT, V_DISP+V_FRONT+V_SYNC), i.e. 1025..1027; this is independent of h_cnt.
- Coordinate and frame-start outputs:
  - xpos = active ? h_cnt : 0; ypos = active ? v_cnt : 0. Both come directly from the counter registers.
  - frame_start = (h_cnt==0 && v_cnt==0).
- Delay line: active, hs_raw and vs_raw pass through a LATENCY-deep shift register so they align with `data_vga_driver`.
- Output register, one stage:
  - vga_de = delayed active.
  - vga_hs = delayed hs_raw ? H_POL : ~H_POL; vga_vs likewise with V_POL.
  - {vga_r, vga_g, vga_b} = delayed active ? data_vga_driver : 16'h0000.
- Blanking is enforced here. Input data during blanking is ignored.

## Timing
- Reset (synchronous, active-high). While rst is high at a clock edge, on that edge:
  - counters, delay line, vga_de and RGB go to 0
  - vga_hs = ~H_POL, vga_vs = ~V_POL
  - xpos = ypos = 0
  - frame_start = 1, since the counters sit at the origin.
- First cycle after reset release: counters = (0,0), frame_start = 1.
- Reset mid-frame:
  - aborts the frame and forces the state above on the next edge
  - no partial sync pulse is stretched
  - the delay line is flushed, so no stale de/sync emerges afterwards.
- Latency:
  - coordinate to pins = LATENCY+1 cycles
  - vga_de first rises LATENCY+1 cycles after the frame_start cycle.
- Line period is 1688 cycles; frame period is 1688×1066 = 1,799,408 cycles.
- hsync pulses continue during vertical blanking. vga_de stays 0 on lines 1024..1065.

## Configuration
- Macro `VGA_DRIVER_BORDER_EN`.
- When defined:
  - a border flag (active && (h_cnt==0 || h_cnt==H_DISP-1 || v_cnt==0 || v_cnt==V_DISP-1)) travels the same delay line
  - flagged active pixels output 16'hFFFF regardless of `data_vga_driver`.
- When undefined: no flag logic exists, and active pixels pass data unmodified.

## Test plan
- **Reset:** hold rst 4 cycles.
  - Expect vga_hs=0, vga_vs=0, vga_de=0, RGB=0, xpos=ypos=0.
  - After release, expect frame_start=1 for exactly one cycle, then xpos counting 1,2,3….
- **Line timing:** across three lines, expect:
  - hs rising edges 1688 cycles apart; hs high for 112 cycles
  - de high for exactly 1280 consecutive cycles per active line
  - hs rise 48 cycles after de fall.
- **Frame timing:**
  - vs period 1,799,408 cycles; vs high for 5064 cycles
  - exactly 1024 de bursts per frame; vs rises 1 line after the last de burst.
- **Latency/alignment:**
  - Stub returns {4'h0, xpos} registered twice (LATENCY=2).
  - Expect the first de cycle to carry 16'h0000 and the 1280th to carry 16'h04FF.
  - Expect de to rise 3 cycles after frame_start.
- **Blanking and mid-frame reset:**
  - data_vga_driver tied to 16'hFFFF: RGB must be 0 whenever de=0.
  - Assert rst for 1 cycle at v_cnt=500, h_cnt=700: next cycle de=0, xpos=0, and frame_start pulses after release.
- **Border:** with input tied to 16'h0000:
  - with `VGA_DRIVER_BORDER_EN` defined, RGB=16'hFFFF on row 0, row 1023, column 0 and column 1279, and 0 elsewhere
  - with it undefined, RGB is 0 everywhere.

Source files
------------

// File: rtl/vga_driver.sv
// vga_driver: 1280x1024@60 timing generator driving latency-aligned sync, DE and RGB565 pins.
// Optional VGA_DRIVER_BORDER_EN forces white on the outermost active rows/columns.
module vga_driver #(
  parameter int   H_DISP  = 1280,
  parameter int   H_FRONT = 48,
  parameter int   H_SYNC  = 112,
  parameter int   H_BACK  = 248,
  parameter int   V_DISP  = 1024,
  parameter int   V_FRONT = 1,
  parameter int   V_SYNC  = 3,
  parameter int   V_BACK  = 38,
  parameter logic H_POL   = 1'b1,
  parameter logic V_POL   = 1'b1,
  parameter int   LATENCY = 2
) (
  input  logic        clk_vga_driver,
  input  logic        rst_vga_driver,
  output logic [11:0] xpos_vga_driver,
  output logic [11:0] ypos_vga_driver,
  output logic        frame_start_vga_driver,
  input  logic [15:0] data_vga_driver,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [4:0]  vga_r,
  output logic [5:0]  vga_g,
  output logic [4:0]  vga_b
);
  localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
`ifdef VGA_DRIVER_BORDER_EN
  localparam int TW = 4;
`else
  localparam int TW = 3;
`endif
  logic [11:0] h_cnt, v_cnt;
  logic active, hs_raw, vs_raw;
  logic [TW-1:0] tap, dq;
  logic [LATENCY-1:0][TW-1:0] dl;
  logic [LATENCY:0][TW-1:0] dl_n;
  logic [15:0] rgb;
  always_ff @(posedge clk_vga_driver) begin
    if (rst_vga_driver) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= (h_cnt == 12'(H_TOTAL-1)) ? '0 : h_cnt + 12'd1;
      if (h_cnt == 12'(H_TOTAL-1))
        v_cnt <= (v_cnt == 12'(V_TOTAL-1)) ? '0 : v_cnt + 12'd1;
    end
  end
  // tap bit order: {border?, vs, hs, active}; oldest stage feeds the output register
  always_comb begin
    active = (h_cnt < 12'(H_DISP)) && (v_cnt < 12'(V_DISP));
    hs_raw = (h_cnt >= 12'(H_DISP+H_FRONT)) && (h_cnt < 12'(H_DISP+H_FRONT+H_SYNC));
    vs_raw = (v_cnt >= 12'(V_DISP+V_FRONT)) && (v_cnt < 12'(V_DISP+V_FRONT+V_SYNC));
`ifdef VGA_DRIVER_BORDER_EN
    tap = {active && (h_cnt == 12'd0 || h_cnt == 12'(H_DISP-1) ||
                      v_cnt == 12'd0 || v_cnt == 12'(V_DISP-1)), vs_raw, hs_raw, active};
`else
    tap = {vs_raw, hs_raw, active};
`endif
  end
  assign dl_n = {dl, tap};
  assign dq = dl[LATENCY-1];
`ifdef VGA_DRIVER_BORDER_EN
  assign rgb = !dq[0] ? 16'h0000 : dq[3] ? 16'hFFFF : data_vga_driver;
`else
  assign rgb = dq[0] ? data_vga_driver : 16'h0000;
`endif
  assign xpos_vga_driver = active ? h_cnt : '0;
  assign ypos_vga_driver = active ? v_cnt : '0;
  assign frame_start_vga_driver = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  always_ff @(posedge clk_vga_driver) begin
    if (rst_vga_driver) begin
      dl <= '0;
      vga_de <= 1'b0;
      vga_hs <= ~H_POL;
      vga_vs <= ~V_POL;
      {vga_r, vga_g, vga_b} <= '0;
    end else begin
      dl <= dl_n[LATENCY-1:0];
      vga_de <= dq[0];
      vga_hs <= dq[1] ? H_POL : ~H_POL;
      vga_vs <= dq[2] ? V_POL : ~V_POL;
      {vga_r, vga_g, vga_b} <= rgb;
    end
  end
endmodule

// File: tb/tb_vga_driver.sv
// tb_vga_driver: directed checks of vga_driver at full 1280x1024 timing and on a scaled 32x14 instance.
module tb_vga_driver;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
`ifdef VGA_DRIVER_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif
  logic rst_f = 1'b1;
  logic [11:0] x_f, y_f;
  logic fs_f, hs_f, vs_f, de_f;
  logic [4:0] r_f, b_f;
  logic [5:0] g_f;
  logic [15:0] s1, s2;
  wire [15:0] rgb_f = {r_f, g_f, b_f};
  always_ff @(posedge clk) begin
    s1 <= {4'h0, x_f};
    s2 <= s1;
  end
  vga_driver u_full (
    .clk_vga_driver(clk), .rst_vga_driver(rst_f),
    .xpos_vga_driver(x_f), .ypos_vga_driver(y_f), .frame_start_vga_driver(fs_f),
    .data_vga_driver(s2), .vga_hs(hs_f), .vga_vs(vs_f), .vga_de(de_f),
    .vga_r(r_f), .vga_g(g_f), .vga_b(b_f));
  logic rst_s = 1'b1;
  logic [15:0] data_s = 16'h0000;
  logic [11:0] x_s, y_s;
  logic fs_s, hs_s, vs_s, de_s;
  logic [4:0] r_s, b_s;
  logic [5:0] g_s;
  wire [15:0] rgb_s = {r_s, g_s, b_s};
  vga_driver #(.H_DISP(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
               .V_DISP(8), .V_FRONT(1), .V_SYNC(3), .V_BACK(2)) u_small (
    .clk_vga_driver(clk), .rst_vga_driver(rst_s),
    .xpos_vga_driver(x_s), .ypos_vga_driver(y_s), .frame_start_vga_driver(fs_s),
    .data_vga_driver(data_s), .vga_hs(hs_s), .vga_vs(vs_s), .vga_de(de_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s));

  task automatic reset_f(input int n);
    rst_f = 1'b1;
    repeat (n) @(negedge clk);
    rst_f = 1'b0;
  endtask
  task automatic reset_s(input int n);
    rst_s = 1'b1;
    repeat (n) @(negedge clk);
    rst_s = 1'b0;
  endtask

  task automatic test_reset();
    rst_f = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (hs_f !== 1'b0) begin errors++; $display("FAIL reset_hs got %0b exp 0", hs_f); end
    checks++; if (vs_f !== 1'b0) begin errors++; $display("FAIL reset_vs got %0b exp 0", vs_f); end
    checks++; if (de_f !== 1'b0) begin errors++; $display("FAIL reset_de got %0b exp 0", de_f); end
    checks++; if (rgb_f !== 16'h0000) begin errors++; $display("FAIL reset_rgb got %h exp 0000", rgb_f); end
    checks++; if (x_f !== 12'd0 || y_f !== 12'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d exp 0,0", x_f, y_f); end
    rst_f = 1'b0;
    checks++; if (fs_f !== 1'b1) begin errors++; $display("FAIL release_fs got %0b exp 1", fs_f); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (fs_f !== 1'b0 || x_f !== 12'(i)) begin errors++; $display("FAIL count_x%0d got fs=%0b x=%0d exp fs=0 x=%0d", i, fs_f, x_f, i); end
    end
  endtask

  task automatic test_latency();
    int first = -1;
    int run = 0;
    reset_f(2);
    checks++; if (fs_f !== 1'b1) begin errors++; $display("FAIL lat_fs got %0b exp 1", fs_f); end
    for (int k = 1; k <= 1300; k++) begin
      @(negedge clk);
      if (de_f === 1'b1) begin
        run++;
        if (first < 0) begin
          first = k;
          checks++; if (rgb_f !== 16'h0000) begin errors++; $display("FAIL lat_first_px got %h exp 0000", rgb_f); end
        end
        if (run == 1280) begin
          checks++; if (rgb_f !== 16'h04FF) begin errors++; $display("FAIL lat_last_px got %h exp 04FF", rgb_f); end
        end
      end
    end
    checks++; if (first != 3) begin errors++; $display("FAIL lat_de_rise got %0d exp 3", first); end
    checks++; if (run != 1280) begin errors++; $display("FAIL lat_de_len got %0d exp 1280", run); end
  endtask

  task automatic test_line_timing();
    int t_hr = -1, t_df = -1, t_dr = -1, n_hr = 0, n_de = 0;
    logic phs = 1'b0, pde = 1'b0;
    reset_f(2);
    for (int t = 0; t < 3*1688 + 1500; t++) begin
      @(negedge clk);
      if (hs_f && !phs) begin
        if (t_hr >= 0) begin
          checks++; if (t - t_hr != 1688) begin errors++; $display("FAIL hs_period got %0d exp 1688", t - t_hr); end
        end
        if (t_df >= 0) begin
          checks++; if (t - t_df != 48) begin errors++; $display("FAIL de_fall_to_hs got %0d exp 48", t - t_df); end
        end
        t_hr = t;
        n_hr++;
      end
      if (!hs_f && phs) begin
        checks++; if (t - t_hr != 112) begin errors++; $display("FAIL hs_width got %0d exp 112", t - t_hr); end
      end
      if (de_f && !pde) t_dr = t;
      if (!de_f && pde) begin
        checks++; if (t - t_dr != 1280) begin errors++; $display("FAIL de_width got %0d exp 1280", t - t_dr); end
        t_df = t;
        n_de++;
      end
      phs = hs_f;
      pde = de_f;
    end
    checks++; if (n_hr != 4) begin errors++; $display("FAIL hs_count got %0d exp 4", n_hr); end
    checks++; if (n_de != 4) begin errors++; $display("FAIL de_count got %0d exp 4", n_de); end
  endtask

  task automatic test_frame_timing();
    int t_vr = -1, t_dr = -1, n_vr = 0, n_burst = 0;
    logic pvs = 1'b0, pde = 1'b0;
    data_s = 16'hFFFF;
    reset_s(2);
    for (int t = 0; t < 3*448; t++) begin
      @(negedge clk);
      checks++; if (rgb_s !== (de_s ? 16'hFFFF : 16'h0000)) begin errors++; $display("FAIL blank_rgb t=%0d de=%0b got %h", t, de_s, rgb_s); end
      if (de_s && !pde) begin
        t_dr = t;
        n_burst++;
      end
      if (vs_s && !pvs) begin
        if (t_vr >= 0) begin
          checks++; if (t - t_vr != 448) begin errors++; $display("FAIL vs_period got %0d exp 448", t - t_vr); end
        end
        checks++; if (n_burst != 8) begin errors++; $display("FAIL de_bursts got %0d exp 8", n_burst); end
        checks++; if (t - t_dr != 64) begin errors++; $display("FAIL last_de_to_vs got %0d exp 64", t - t_dr); end
        t_vr = t;
        n_burst = 0;
        n_vr++;
      end
      if (!vs_s && pvs) begin
        checks++; if (t - t_vr != 96) begin errors++; $display("FAIL vs_width got %0d exp 96", t - t_vr); end
      end
      pvs = vs_s;
      pde = de_s;
    end
    checks++; if (n_vr != 3) begin errors++; $display("FAIL vs_count got %0d exp 3", n_vr); end
  endtask

  task automatic test_mid_frame_reset();
    data_s = 16'hFFFF;
    reset_s(2);
    repeat (4*32 + 10) @(negedge clk);
    checks++; if (x_s !== 12'd10 || y_s !== 12'd4 || de_s !== 1'b1) begin errors++; $display("FAIL mid_pos got x=%0d y=%0d de=%0b exp 10,4,1", x_s, y_s, de_s); end
    rst_s = 1'b1;
    @(negedge clk);
    checks++; if (de_s !== 1'b0 || rgb_s !== 16'h0000) begin errors++; $display("FAIL mid_de_rgb got de=%0b rgb=%h exp 0,0000", de_s, rgb_s); end
    checks++; if (x_s !== 12'd0 || y_s !== 12'd0) begin errors++; $display("FAIL mid_xy got %0d,%0d exp 0,0", x_s, y_s); end
    checks++; if (hs_s !== 1'b0 || vs_s !== 1'b0) begin errors++; $display("FAIL mid_sync got hs=%0b vs=%0b exp 0,0", hs_s, vs_s); end
    rst_s = 1'b0;
    checks++; if (fs_s !== 1'b1) begin errors++; $display("FAIL mid_fs got %0b exp 1", fs_s); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (fs_s !== 1'b0 || de_s !== (i == 3)) begin errors++; $display("FAIL mid_flush%0d got fs=%0b de=%0b exp fs=0 de=%0b", i, fs_s, de_s, i == 3); end
    end
  endtask

  task automatic test_border();
    int c, h, v, hk, vk;
    logic act, edge_px;
    logic [15:0] exp_rgb;
    data_s = 16'h0000;
    reset_s(2);
    for (int k = 0; k < 448 + 4; k++) begin
      hk = k % 32;
      vk = (k / 32) % 14;
      checks++; if (x_s !== ((hk < 16 && vk < 8) ? 12'(hk) : 12'd0)) begin errors++; $display("FAIL border_xpos k=%0d got %0d exp %0d", k, x_s, (hk < 16 && vk < 8) ? hk : 0); end
      c = k - 3;
      h = (c < 0) ? 99 : c % 32;
      v = (c < 0) ? 99 : (c / 32) % 14;
      act = (h < 16) && (v < 8);
      edge_px = (h == 0) || (h == 15) || (v == 0) || (v == 7);
      exp_rgb = (act && edge_px && BORDER) ? 16'hFFFF : 16'h0000;
      checks++; if (de_s !== act || rgb_s !== exp_rgb) begin errors++; $display("FAIL border_px h=%0d v=%0d got de=%0b rgb=%h exp de=%0b rgb=%h", h, v, de_s, rgb_s, act, exp_rgb); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_line_timing();
    test_frame_timing();
    test_mid_frame_reset();
    test_border();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
